// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - instruction memory and decode handshake bundle for instr_fetch_queue
//
// Purpose: groups the instruction-memory request/response and decode valid/ready
//          signals so the fetch queue and its neighbours connect through one port.
// Signals:
//   mem_req      fetch -> memory  read request
//   mem_addr     fetch -> memory  read address, stable while mem_req and no ack
//   mem_ack      memory -> fetch  mem_rdata valid this cycle (only with mem_req)
//   mem_rdata    memory -> fetch  instruction word
//   instr_valid  fetch -> decode  head of queue valid
//   instr        fetch -> decode  head instruction
//   instr_pc     fetch -> decode  address of head instruction
//   instr_ready  decode -> fetch  head accepted this cycle
// Modports: master = fetch queue side, slave = memory/decode side.

interface instr_fetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch PC owner, sequential instruction fetch and instruction FIFO
//
// Purpose: issues one sequential word read at a time to instruction memory, buffers
//          returned words with their addresses in a DEPTH-entry FIFO, and presents
//          the head to decode. Redirects flush the FIFO and restart fetch.
// Ports:
//   Clock       rising-edge clock
//   Reset_L     asynchronous active-low reset; fetch PC tracks startPC while low
//   startPC     initial fetch PC
//   redirect    one-cycle pulse: flush and restart at redirectPC
//   redirectPC  redirect target
//   bus         instr_fetch_queue_if.master (memory request/response, decode handshake)

module instr_fetch_queue #(
    parameter int          DEPTH  = 4,
    parameter logic [31:0] PC_INC = 32'd4
) (
    input  logic                       Clock,
    input  logic                       Reset_L,
    input  logic [31:0]                startPC,
    input  logic                       redirect,
    input  logic [31:0]                redirectPC,
    instr_fetch_queue_if.master        bus
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        FETCH,
        DISCARD
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     saved_pc_q, saved_pc_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            mem_req;
    logic            ack_fire;
    logic            push;
    logic            pop;

    // Reset_L gates the request combinationally so it drops the moment reset
    // asserts, abandoning any outstanding read without waiting for a clock.
    assign mem_req  = Reset_L & ((state_q == DISCARD) | (count_q < FULL_COUNT));
    assign ack_fire = mem_req & bus.mem_ack;
    assign push     = (state_q == FETCH) & ack_fire & ~redirect;
    assign pop      = bus.instr_valid & bus.instr_ready;

    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = data_mem[rd_ptr_q];
    assign bus.instr_pc    = pc_mem[rd_ptr_q];

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= FETCH;
            fetch_pc_q <= startPC;
            saved_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    // fetch_pc only moves when the outstanding read completes or is retargeted
    // with nothing in flight, which keeps mem_addr stable until the ack. A
    // redirect that lands mid-request parks its target in saved_pc and lets
    // DISCARD swallow the stale word.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        saved_pc_d = saved_pc_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    if (!mem_req || bus.mem_ack) begin
                        fetch_pc_d = redirectPC;
                    end else begin
                        saved_pc_d = redirectPC;
                        state_d    = DISCARD;
                    end
                end else if (ack_fire) begin
                    fetch_pc_d = fetch_pc_q + PC_INC;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) begin
                    fetch_pc_d = redirect ? redirectPC : saved_pc_q;
                    state_d    = FETCH;
                end else if (redirect) begin
                    saved_pc_d = redirectPC;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            data_mem[wr_ptr_q] <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue

module tb_instr_fetch_queue;

    localparam logic [31:0] KEY  = 32'h5A5A_0F0F;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        Clock;
    logic        Reset_L;
    logic [31:0] startPC;
    logic        redirect;
    logic [31:0] redirectPC;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH  (4),
        .PC_INC (32'd4)
    ) dut (
        .Clock      (Clock),
        .Reset_L    (Reset_L),
        .startPC    (startPC),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .bus        (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_target;
    bit          m_disc;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input logic ack, input logic rdy);
        bus.mem_ack     = ack;
        bus.instr_ready = rdy;
        bus.mem_rdata   = bus.mem_addr ^ KEY;
    endtask

    task automatic do_reset(input logic [31:0] pc);
        Reset_L    = 1'b0;
        startPC    = pc;
        redirect   = 1'b0;
        redirectPC = '0;
        drive(1'b0, 1'b0);
        cyc();
        cyc();
        Reset_L = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        Reset_L    = 1'b0;
        startPC    = BASE;
        redirect   = 1'b0;
        redirectPC = '0;
        drive(1'b0, 1'b0);
        cyc();
        vectors++;
        if (bus.mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_req: got %0b expected 0", bus.mem_req);
        end
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_instr_valid: got %0b expected 0", bus.instr_valid);
        end
        vectors++;
        if (bus.mem_addr !== BASE) begin
            miscompares++;
            $display("FAIL reset_mem_addr: got %h expected %h", bus.mem_addr, BASE);
        end
        Reset_L = 1'b1;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL release_mem_req: got %0b expected 1", bus.mem_req);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset(BASE);
        for (int i = 0; i < 6; i++) begin
            exp = BASE + 32'(4 * i);
            vectors++;
            if (bus.mem_addr !== exp) begin
                miscompares++;
                $display("FAIL seq_addr[%0d]: got %h expected %h", i, bus.mem_addr, exp);
            end
            vectors++;
            if (i == 0) begin
                if (bus.instr_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL seq_first_valid: got %0b expected 0", bus.instr_valid);
                end
            end else if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp - 32'd4 ||
                         bus.instr !== ((exp - 32'd4) ^ KEY)) begin
                miscompares++;
                $display("FAIL seq_head[%0d]: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, exp - 32'd4, (exp - 32'd4) ^ KEY);
            end
            drive(1'b1, 1'b1);
            cyc();
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_stall();
        int pushes = 0;
        do_reset(BASE);
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req === 1'b1) pushes++;
            drive(1'b1, 1'b0);
            cyc();
        end
        vectors++;
        if (pushes != 4 || bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_full: got pushes=%0d req=%0b valid=%0b expected pushes=4 req=0 valid=1",
                     pushes, bus.mem_req, bus.instr_valid);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== BASE + 32'(4 * k) ||
                bus.instr !== ((BASE + 32'(4 * k)) ^ KEY)) begin
                miscompares++;
                $display("FAIL stall_drain[%0d]: got v=%0b pc=%h expected v=1 pc=%h",
                         k, bus.instr_valid, bus.instr_pc, BASE + 32'(4 * k));
            end
            drive(1'b0, 1'b1);
            cyc();
        end
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== BASE + 32'h10) begin
            miscompares++;
            $display("FAIL stall_resume: got v=%0b req=%0b addr=%h expected v=0 req=1 addr=%h",
                     bus.instr_valid, bus.mem_req, bus.mem_addr, BASE + 32'h10);
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_redirect_wait();
        do_reset(BASE);
        drive(1'b0, 1'b1);
        cyc();
        redirect   = 1'b1;
        redirectPC = BASE + 32'h100;
        cyc();
        redirect = 1'b0;
        vectors++;
        if (bus.mem_addr !== BASE || bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rdw_hold: got addr=%h req=%0b v=%0b expected addr=%h req=1 v=0",
                     bus.mem_addr, bus.mem_req, bus.instr_valid, BASE);
        end
        cyc();
        drive(1'b1, 1'b1);
        cyc();
        vectors++;
        if (bus.mem_addr !== BASE + 32'h100 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rdw_restart: got addr=%h v=%0b expected addr=%h v=0",
                     bus.mem_addr, bus.instr_valid, BASE + 32'h100);
        end
        drive(1'b1, 1'b1);
        cyc();
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== BASE + 32'h100 ||
            bus.instr !== ((BASE + 32'h100) ^ KEY)) begin
            miscompares++;
            $display("FAIL rdw_first: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                     bus.instr_valid, bus.instr_pc, bus.instr, BASE + 32'h100, (BASE + 32'h100) ^ KEY);
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_redirect_ack();
        do_reset(BASE);
        drive(1'b1, 1'b0);
        cyc();
        drive(1'b1, 1'b0);
        cyc();
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.mem_addr !== BASE + 32'd8) begin
            miscompares++;
            $display("FAIL rda_setup: got v=%0b addr=%h expected v=1 addr=%h",
                     bus.instr_valid, bus.mem_addr, BASE + 32'd8);
        end
        redirect   = 1'b1;
        redirectPC = BASE + 32'h200;
        drive(1'b1, 1'b1);
        cyc();
        redirect = 1'b0;
        vectors++;
        if (bus.instr_valid !== 1'b0 || bus.mem_addr !== BASE + 32'h200 || bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL rda_flush: got v=%0b addr=%h req=%0b expected v=0 addr=%h req=1",
                     bus.instr_valid, bus.mem_addr, bus.mem_req, BASE + 32'h200);
        end
        drive(1'b1, 1'b1);
        cyc();
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== BASE + 32'h200) begin
            miscompares++;
            $display("FAIL rda_first: got v=%0b pc=%h expected v=1 pc=%h",
                     bus.instr_valid, bus.instr_pc, BASE + 32'h200);
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_double_redirect();
        do_reset(BASE);
        drive(1'b0, 1'b1);
        redirect   = 1'b1;
        redirectPC = 32'h0000_0100;
        cyc();
        redirect = 1'b0;
        cyc();
        redirect   = 1'b1;
        redirectPC = 32'h0000_0200;
        cyc();
        redirect = 1'b0;
        vectors++;
        if (bus.mem_addr !== BASE || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL dbl_hold: got addr=%h v=%0b expected addr=%h v=0",
                     bus.mem_addr, bus.instr_valid, BASE);
        end
        drive(1'b1, 1'b1);
        cyc();
        vectors++;
        if (bus.mem_addr !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL dbl_restart: got addr=%h expected 00000200", bus.mem_addr);
        end
        drive(1'b1, 1'b1);
        cyc();
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL dbl_first: got v=%0b pc=%h expected v=1 pc=00000200",
                     bus.instr_valid, bus.instr_pc);
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset(BASE);
        drive(1'b1, 1'b0);
        cyc();
        drive(1'b0, 1'b0);
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== BASE + 32'd4) begin
            miscompares++;
            $display("FAIL arst_setup: got v=%0b req=%0b addr=%h expected v=1 req=1 addr=%h",
                     bus.instr_valid, bus.mem_req, bus.mem_addr, BASE + 32'd4);
        end
        startPC = 32'h0080_0000;
        #2;
        Reset_L = 1'b0;
        #1;
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_immediate: got req=%0b v=%0b expected req=0 v=0",
                     bus.mem_req, bus.instr_valid);
        end
        drive(1'b1, 1'b0);
        cyc();
        Reset_L = 1'b1;
        drive(1'b0, 1'b0);
        #1;
        vectors++;
        if (bus.mem_addr !== 32'h0080_0000 || bus.mem_req !== 1'b1 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_release: got addr=%h req=%0b v=%0b expected addr=00800000 req=1 v=0",
                     bus.mem_addr, bus.mem_req, bus.instr_valid);
        end
        cyc();
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_late_ack: got v=%0b expected 0", bus.instr_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        exp[0] = 32'hFFFF_FFF8;
        exp[1] = 32'hFFFF_FFFC;
        exp[2] = 32'h0000_0000;
        exp[3] = 32'h0000_0004;
        do_reset(32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1);
            cyc();
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp[i] || bus.instr !== (exp[i] ^ KEY)) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got v=%0b pc=%h expected v=1 pc=%h",
                         i, bus.instr_valid, bus.instr_pc, exp[i]);
            end
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] base;
        logic [31:0] tgt;
        logic [31:0] data;
        logic [63:0] head;
        bit          exp_req;
        bit          a, r, rd, acc, pop;
        base       = $urandom;
        base[1:0]  = 2'b00;
        do_reset(base);
        m_q.delete();
        m_pc     = base;
        m_target = '0;
        m_disc   = 1'b0;
        for (int n = 0; n < 600; n++) begin
            exp_req = m_disc || (m_q.size() < 4);
            vectors++;
            if (bus.mem_req !== exp_req || bus.mem_addr !== m_pc) begin
                miscompares++;
                $display("FAIL rand_req[%0d]: got req=%0b addr=%h expected req=%0b addr=%h",
                         n, bus.mem_req, bus.mem_addr, exp_req, m_pc);
            end
            vectors++;
            if (m_q.size() == 0) begin
                if (bus.instr_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_empty[%0d]: got v=%0b expected 0", n, bus.instr_valid);
                end
            end else begin
                head = m_q[0];
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== head[63:32] || bus.instr !== head[31:0]) begin
                    miscompares++;
                    $display("FAIL rand_head[%0d]: got v=%0b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                             n, bus.instr_valid, bus.instr_pc, bus.instr, head[63:32], head[31:0]);
                end
            end
            a   = ($urandom_range(0, 9) < 5);
            r   = ($urandom_range(0, 9) < 5);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            data = $urandom;
            bus.mem_ack     = a && exp_req;
            bus.mem_rdata   = data;
            bus.instr_ready = r;
            redirect        = rd;
            redirectPC      = tgt;

            acc = a && exp_req;
            pop = r && (m_q.size() != 0);
            if (rd) begin
                m_q.delete();
                if (m_disc) begin
                    if (acc) begin
                        m_pc   = tgt;
                        m_disc = 1'b0;
                    end else begin
                        m_target = tgt;
                    end
                end else if (!exp_req || acc) begin
                    m_pc = tgt;
                end else begin
                    m_disc   = 1'b1;
                    m_target = tgt;
                end
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_disc) begin
                    if (acc) begin
                        m_pc   = m_target;
                        m_disc = 1'b0;
                    end
                end else if (acc) begin
                    m_q.push_back({m_pc, data});
                    m_pc = m_pc + 32'd4;
                end
            end
            cyc();
        end
        redirect = 1'b0;
        drive(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_double_redirect();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
